ps2_scan_decoder: RTL and testbench

Downstream stage of the PS/2 receiver: consumes each received byte (strobe plus 8-bit data) and decodes scan-code set 2 prefix sequences (E0 extended, F0 break, E1 pause) into single key events. Events are queued in a small show-ahead FIFO for the display/control logic. A separate register holds the most recent make code for the 7-segment driver.

---
 rtl/ps2_scan_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder
// Turns the raw PS/2 scan-code set 2 byte stream into single key events.
// The E0 (extended), F0 (break) and E1 (pause) prefixes are folded into one
// 10-bit event {ext, brk, code}. Events go into a small show-ahead FIFO.
// The most recent make code is also held for the 7-segment display.

module ps2_scan_decoder #(
  parameter int DEPTH = 4                 // event FIFO depth, power of two, 2..16
) (
  input  logic       clk,
  input  logic       rst,                 // asynchronous, active-low
  input  logic       rx_tick,
  input  logic [7:0] rx_byte,
  input  logic       ev_rd,
  input  logic       ovf_clr,
  output logic       ev_valid,
  output logic [9:0] ev_data,
  output logic [8:0] last_make,
  output logic       ovf,
  output logic       ctrl_byte
);

  localparam int AW = $clog2(DEPTH);     // FIFO address width
  localparam int PW = AW + 1;            // pointer width with wrap bit

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] B_PAUSE = 8'hE1;

  // The pause sequence is E1 followed by seven bytes that carry no key information.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } state_t;

  // ---------------------------------------------------------------------------
  // Decoder FSM
  // ---------------------------------------------------------------------------
  state_t     state, state_nxt;
  logic [2:0] skip, skip_nxt;
  logic       push;
  logic [9:0] push_ev;
  logic       ctrl_hit;

  // Keyboard status and control replies. They are recognised only in IDLE.
  function automatic logic is_ctrl(input logic [7:0] b);
    logic hit;
    case (b)
      8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE: hit = 1'b1;
      default:                                 hit = 1'b0;
    endcase
    return hit;
  endfunction

  // State register for the prefix decoder and the pause skip counter.
  // NOTE: all sequential state uses non-blocking assignments.  Every register
  // then samples the values from before the edge, whatever the block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      skip  <= '0;
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
    end
  end

  // Next-state and event generation. Nothing moves unless a byte arrives.
  // NOTE: every output of this block gets a default first.  If a path left
  // one unassigned, synthesis would infer a latch.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    push      = 1'b0;
    push_ev   = '0;
    ctrl_hit  = 1'b0;
    if (rx_tick) begin
      case (state)
        IDLE: begin
          if (rx_byte == B_EXT) begin
            state_nxt = EXT;
          end else if (rx_byte == B_BRK) begin
            state_nxt = BRK;
          end else if (rx_byte == B_PAUSE) begin
            state_nxt = PAUSE;
            skip_nxt  = PAUSE_SKIP;
          end else if (is_ctrl(rx_byte)) begin
            ctrl_hit = 1'b1;
          end else begin
            push    = 1'b1;
            push_ev = {2'b00, rx_byte};
          end
        end
        EXT: begin
          if (rx_byte == B_BRK) begin
            state_nxt = EXT_BRK;
          end else if (rx_byte != B_EXT) begin
            // A repeated E0 leaves the decoder in EXT.
            push      = 1'b1;
            push_ev   = {2'b10, rx_byte};
            state_nxt = IDLE;
          end
        end
        BRK: begin
          push      = 1'b1;
          push_ev   = {2'b01, rx_byte};
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          push      = 1'b1;
          push_ev   = {2'b11, rx_byte};
          state_nxt = IDLE;
        end
        PAUSE: begin
          skip_nxt = skip - 3'd1;
          if (skip == 3'd1) begin
            // The last trailing byte completes the sequence. The whole sequence
            // is reported as one extended E1 make.
            push      = 1'b1;
            push_ev   = {2'b10, B_PAUSE};
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          skip_nxt  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full;
  logic          do_pop, do_push, overflow;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still
  // accepted. When full, it writes the slot that is being popped.
  assign do_pop   = ev_rd && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;

  // Event storage. It is written only, with no reset.
  // NOTE: the storage array is not reset.  The pointers alone define which
  // entries are valid, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_ev;
    end
  end

  // Read and write pointers. The extra wrap bit tells full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  assign ev_valid = !empty;
  assign ev_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------

  // Sticky overflow flag. A new overflow wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (overflow) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Most recent make code, for the display. It updates even if the FIFO dropped the event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_make <= '0;
    end else if (push && !push_ev[8]) begin
      last_make <= {push_ev[9], push_ev[7:0]};
    end
  end

  // One-cycle pulse for each control byte that was received and discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_byte <= 1'b0;
    end else begin
      ctrl_byte <= ctrl_hit;
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder.
// A behavioural model decodes the byte stream with prefix flags and a
// remaining-byte count for pause. It keeps the event FIFO as a queue.
// Directed test-plan sequences come first, then a randomized run.

module tb_ps2_scan_decoder;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       rx_tick;
  logic [7:0] rx_byte;
  logic       ev_rd;
  logic       ovf_clr;
  logic       ev_valid;
  logic [9:0] ev_data;
  logic [8:0] last_make;
  logic       ovf;
  logic       ctrl_byte;

  int checks   = 0;
  int failures = 0;

  ps2_scan_decoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_tick   (rx_tick),
    .rx_byte   (rx_byte),
    .ev_rd     (ev_rd),
    .ovf_clr   (ovf_clr),
    .ev_valid  (ev_valid),
    .ev_data   (ev_data),
    .last_make (last_make),
    .ovf       (ovf),
    .ctrl_byte (ctrl_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  logic [9:0] mq[$];
  bit         m_ext;
  bit         m_brk;
  int         m_pause_left;
  logic [8:0] m_last;
  logic       m_ovf;
  logic       m_ctrl;

  function automatic bit is_ctrl_code(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hFF) || (b == 8'hAA) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ext        = 1'b0;
    m_brk        = 1'b0;
    m_pause_left = 0;
    m_last       = '0;
    m_ovf        = 1'b0;
    m_ctrl       = 1'b0;
  endtask

  // Apply one clock edge's worth of inputs to the model.
  task automatic model_step(input logic t, input logic [7:0] b,
                            input logic rd, input logic clr);
    bit         have_ev;
    logic [9:0] ev;
    bit         popped;
    bit         dropped;
    have_ev = 1'b0;
    ev      = '0;
    dropped = 1'b0;
    m_ctrl  = 1'b0;
    if (t) begin
      if (m_pause_left > 0) begin
        m_pause_left = m_pause_left - 1;
        if (m_pause_left == 0) begin
          have_ev = 1'b1;
          ev      = {2'b10, 8'hE1};
        end
      end else if (!m_ext && !m_brk) begin
        if (b == 8'hE0)              m_ext = 1'b1;
        else if (b == 8'hF0)         m_brk = 1'b1;
        else if (b == 8'hE1)         m_pause_left = 7;
        else if (is_ctrl_code(b))    m_ctrl = 1'b1;
        else begin
          have_ev = 1'b1;
          ev      = {2'b00, b};
        end
      end else if (m_brk) begin
        have_ev = 1'b1;
        ev      = {m_ext, 1'b1, b};
        m_ext   = 1'b0;
        m_brk   = 1'b0;
      end else begin
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b != 8'hE0) begin
          have_ev = 1'b1;
          ev      = {2'b10, b};
          m_ext   = 1'b0;
        end
      end
    end
    popped = rd && (mq.size() > 0);
    if (popped) void'(mq.pop_front());
    if (have_ev) begin
      if (!ev[8]) m_last = {ev[9], ev[7:0]};
      if (mq.size() < DEPTH) mq.push_back(ev);
      else dropped = 1'b1;
    end
    if (dropped)  m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string where);
    logic [9:0] head;
    head = (mq.size() > 0) ? mq[0] : 10'h000;
    check({where, ".ev_valid"},  16'(ev_valid),  16'(mq.size() > 0));
    check({where, ".ev_data"},   16'(ev_data),   16'(head));
    check({where, ".last_make"}, 16'(last_make), 16'(m_last));
    check({where, ".ovf"},       16'(ovf),       16'(m_ovf));
    check({where, ".ctrl_byte"}, 16'(ctrl_byte), 16'(m_ctrl));
  endtask

  // One clock cycle. Inputs are driven at the negedge; outputs are checked
  // at the following negedge.
  task automatic cycle(input string where, input logic t, input logic [7:0] b,
                       input logic rd, input logic clr);
    rx_tick = t;
    rx_byte = b;
    ev_rd   = rd;
    ovf_clr = clr;
    @(posedge clk);
    model_step(t, b, rd, clr);
    @(negedge clk);
    rx_tick = 1'b0;
    ev_rd   = 1'b0;
    ovf_clr = 1'b0;
    compare_all(where);
  endtask

  task automatic send(input string where, input logic [7:0] b);
    cycle(where, 1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic pop(input string where);
    cycle(where, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic drain(input string where);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (ev_valid) pop(where);
    end
    check({where, ".empty"}, 16'(ev_valid), 16'(0));
  endtask

  task automatic pulse_reset(input string where);
    rst = 1'b0;
    model_reset();
    #1;
    compare_all({where, ".async"});
    repeat (2) @(negedge clk);
    compare_all({where, ".held"});
    rst = 1'b1;
  endtask

  function automatic logic [7:0] pick_byte();
    int r;
    logic [7:0] ctl [6];
    ctl = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE};
    r = $urandom_range(0, 19);
    if (r < 3)       return 8'hE0;
    else if (r < 6)  return 8'hF0;
    else if (r == 6) return 8'hE1;
    else if (r < 9)  return ctl[$urandom_range(0, 5)];
    else             return 8'($urandom_range(0, 255));
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst     = 1'b0;
    rx_tick = 1'b0;
    rx_byte = 8'h00;
    ev_rd   = 1'b0;
    ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    check("reset.ev_data0", 16'(ev_data), 16'h0000);
    rst = 1'b1;

    // Plain make/break, back to back.
    send("mk", 8'h1C);
    check("mk.head", 16'(ev_data), 16'h001C);
    send("mk_f0", 8'hF0);
    send("mk_brk", 8'h1C);
    check("mk.last", 16'(last_make), 16'h001C);
    pop("mk_pop1");
    check("mk.second", 16'(ev_data), 16'h011C);
    pop("mk_pop2");
    check("mk.drained", 16'(ev_valid), 16'(0));

    // Extended make and break.
    send("ext_e0", 8'hE0);
    send("ext_mk", 8'h75);
    check("ext.head", 16'(ev_data), 16'h0275);
    send("ext_e0b", 8'hE0);
    send("ext_f0", 8'hF0);
    send("ext_brk", 8'h75);
    check("ext.last", 16'(last_make), 16'h0175);
    pop("ext_pop1");
    check("ext.second", 16'(ev_data), 16'h0375);
    drain("ext_drain");

    // Pause sequence yields exactly one event.
    send("pause_e1", 8'hE1);
    send("pause_b1", 8'h14);
    send("pause_b2", 8'h77);
    send("pause_b3", 8'hE1);
    send("pause_b4", 8'hF0);
    send("pause_b5", 8'h14);
    send("pause_b6", 8'hF0);
    check("pause.none_yet", 16'(ev_valid), 16'(0));
    send("pause_b7", 8'h77);
    check("pause.event", 16'(ev_data), 16'h02E1);
    check("pause.last", 16'(last_make), 16'h01E1);
    pop("pause_pop");
    check("pause.single", 16'(ev_valid), 16'(0));
    send("pause_next", 8'h1C);
    check("pause.next", 16'(ev_data), 16'h001C);
    drain("pause_drain");

    // Control bytes in IDLE pulse ctrl_byte; after E0 they are key codes.
    send("ctl_aa", 8'hAA);
    check("ctl.aa_pulse", 16'(ctrl_byte), 16'(1));
    send("ctl_fa", 8'hFA);
    check("ctl.fa_pulse", 16'(ctrl_byte), 16'(1));
    cycle("ctl_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    check("ctl.pulse_end", 16'(ctrl_byte), 16'(0));
    check("ctl.no_event", 16'(ev_valid), 16'(0));
    send("ctl_e0", 8'hE0);
    send("ctl_ext_aa", 8'hAA);
    check("ctl.ext_aa", 16'(ev_data), 16'h02AA);
    drain("ctl_drain");

    // Overflow behaviour with DEPTH=4.
    send("ovf_m1", 8'h15);
    send("ovf_m2", 8'h16);
    send("ovf_m3", 8'h1A);
    send("ovf_m4", 8'h1E);
    check("ovf.not_yet", 16'(ovf), 16'(0));
    send("ovf_m5", 8'h21);
    check("ovf.set", 16'(ovf), 16'(1));
    check("ovf.head", 16'(ev_data), 16'h0015);
    check("ovf.last_dropped", 16'(last_make), 16'h0021);
    cycle("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf.cleared", 16'(ovf), 16'(0));
    cycle("ovf_pushpop", 1'b1, 8'h22, 1'b1, 1'b0);
    check("ovf.pushpop_noset", 16'(ovf), 16'(0));
    check("ovf.pushpop_head", 16'(ev_data), 16'h0016);
    cycle("ovf_set_wins", 1'b1, 8'h26, 1'b0, 1'b1);
    check("ovf.set_wins", 16'(ovf), 16'(1));
    pop("ovf_d1");
    check("ovf.d1", 16'(ev_data), 16'h001A);
    pop("ovf_d2");
    check("ovf.d2", 16'(ev_data), 16'h001E);
    pop("ovf_d3");
    check("ovf.d3", 16'(ev_data), 16'h0022);
    pop("ovf_d4");
    check("ovf.d4_empty", 16'(ev_valid), 16'(0));
    pop("ovf_pop_empty");
    cycle("ovf_clr2", 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset after E0 returns the decoder to IDLE.
    send("rst_e0", 8'hE0);
    pulse_reset("rst_ext");
    send("rst_next", 8'h1C);
    check("rst.next_plain", 16'(ev_data), 16'h001C);

    // Reset during the pause skip, with an event queued, flushes everything.
    send("rst_pause_e1", 8'hE1);
    send("rst_pause_b1", 8'h14);
    pulse_reset("rst_pause");
    check("rst.flushed", 16'(ev_valid), 16'(0));
    send("rst_pause_next", 8'h1C);
    check("rst.pause_next", 16'(ev_data), 16'h001C);
    drain("rst_drain");

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle("rand",
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            pick_byte(),
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
